dcache_ctrl: RTL

//  Sequencing FSM for the pipelined core's 2-way set-associative data cache (one word per block).

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_if.sv | 36 +++
 rtl/dcache_sat_counter.sv | 19 +
 rtl/dcache_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the data-cache sequencing controller.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    REFILL  = 2'd2,
    WR_THRU = 2'd3
  } dcache_state_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dcache_if.sv
// Bundles the MEM-stage, cache-array and main-memory signals seen by dcache_ctrl.
interface dcache_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [DATA_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;
  logic                  cache_hit;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic [DATA_WIDTH-1:0] cache_addr;
  logic                  cache_we;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Controller side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ready, mem_rdata,
    output cpu_rdata, cpu_stall, cache_addr, cache_we, cache_wdata, mem_req, mem_we, mem_addr,
           mem_wdata
  );

  // Pipeline / cache array / memory side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cache_hit, cache_rdata, mem_ready, mem_rdata,
    input  cpu_rdata, cpu_stall, cache_addr, cache_we, cache_wdata, mem_req, mem_we, mem_addr,
           mem_wdata
  );
endinterface

// File: rtl/dcache_sat_counter.sv
// 32-bit saturating event counter; only built when DCACHE_STATS_EN is defined.
`ifdef DCACHE_STATS_EN
module sat_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [31:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/dcache_ctrl.sv
// Sequencing FSM for the 2-way write-through/allocate data cache.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  dcache_if.slave        bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]    hit_cnt,
  output logic [31:0]    miss_cnt
`endif
);

  dcache_state_t         state;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) begin
              addr_q <= bus.cpu_addr;
              data_q <= bus.cpu_wdata;
              state  <= WR_THRU;
            end else if (!bus.cache_hit) begin
              addr_q <= bus.cpu_addr;
              state  <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (bus.mem_ready) begin
            data_q <= bus.mem_rdata;
            state  <= REFILL;
          end
        end
        REFILL:  state <= IDLE;
        WR_THRU: begin
          if (bus.mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode from state; in IDLE and WR_THRU they also follow the live inputs
  // so hits and write-through completion cost no extra cycle.
  always_comb begin
    bus.cpu_rdata   = data_q;
    bus.cpu_stall   = 1'b0;
    bus.cache_addr  = addr_q;
    bus.cache_we    = 1'b0;
    bus.cache_wdata = data_q;
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = addr_q;
    bus.mem_wdata   = data_q;
    case (state)
      IDLE: begin
        bus.cache_addr = bus.cpu_addr;
        bus.cpu_rdata  = bus.cache_rdata;
        bus.cpu_stall  = bus.cpu_req && (bus.cpu_we || !bus.cache_hit);
      end
      RD_MISS: begin
        bus.mem_req   = 1'b1;
        bus.cpu_stall = 1'b1;
      end
      REFILL: begin
        bus.cache_we = 1'b1;
      end
      WR_THRU: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.cpu_stall = !bus.mem_ready;
        bus.cache_we  = bus.mem_ready;
      end
      default: ;
    endcase
  end

`ifdef DCACHE_STATS_EN
  logic hit_inc;
  logic miss_inc;

  assign hit_inc  = (state == IDLE) && bus.cpu_req && !bus.cpu_we && bus.cache_hit;
  assign miss_inc = (state == IDLE) && bus.cpu_req && !bus.cpu_we && !bus.cache_hit;

  sat_counter u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_inc),
    .cnt (hit_cnt)
  );

  sat_counter u_miss_cnt (
    .clk (clk),
    .rst (rst),
    .inc (miss_inc),
    .cnt (miss_cnt)
  );
`endif

endmodule
